stage3_mem_req: RTL and testbench
=================================

Name: stage3_mem_req

Overview:
- Data-side request issuer of the EX stage. Drives the SRAM-like data interface (req/addr_ok) and gates EX readiness on the address handshake.
- Tracks accepted-but-unreturned requests.
- Masks stale data_ok responses belonging to flushed instructions, so the downstream MEM stage only sees data_ok for live loads/stores.

Parameters:
- MAX_OUTS, 2, maximum accepted requests awaiting data_ok (outstanding plus discard); issue is blocked at this limit.
- CNT_W, 2, width of the outstanding and discard counters; must satisfy 2^CNT_W > MAX_OUTS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ertn_flush  in  1  pipeline flush (ertn)
- wb_ex  in  1  pipeline flush (exception at WB)
- tlb_reflush  in  1  pipeline flush (TLB refetch)
- es_valid  in  1  EX holds a valid instruction
- es_mem_req  in  1  EX instruction is a load or store
- es_mem_we  in  1  1 = store, 0 = load
- es_mem_size  in  2  0 = byte, 1 = half, 2 = word
- es_addr  in  32  physical address
- es_store_data  in  32  store source (low bits significant)
- es_ex  in  1  EX instruction carries an exception (ALE, TLB, ...)
- ms_has_int  in  1  older instruction in MEM carries an exception
- ws_has_int  in  1  older instruction in WB carries an exception
- ms_allow_in  in  1  MEM accepts EX this cycle
- es_mem_ready_go  out  1  memory part of EX is ready to advance
- data_sram_req  out  1
- data_sram_wr  out  1
- data_sram_size  out  2
- data_sram_addr  out  32
- data_sram_wstrb  out  4
- data_sram_wdata  out  32
- data_sram_addr_ok  in  1
- data_sram_data_ok  in  1
- ms_data_ok  out  1  data_ok filtered for MEM
- mem_outstanding  out  CNT_W  accepted requests awaiting data_ok

Behaviour:
- flush = ertn_flush | wb_ex | tlb_reflush.
- suppress = es_ex | ms_has_int | ws_has_int | flush | (outstanding + discard_cnt == MAX_OUTS).
- issue = es_valid & es_mem_req & ~suppress.
- Reset (reset = 0, async):
  - state IDLE; outstanding, discard_cnt and latched fields = 0.
  - All outputs 0, except es_mem_ready_go = 1.
- States:
  - IDLE: data_sram_* driven combinationally from es_* inputs; data_sram_req = issue. On issue, fields latch into registers. addr_ok in the same cycle → ACC, otherwise → REQ.
  - REQ: req = 1 from latched fields, held stable until addr_ok. Fields never change and req is never withdrawn.
    - addr_ok → ACC.
    - flush without addr_ok → DRAIN.
    - flush with addr_ok → IDLE; the request counts toward discard.
  - ACC: req = 0; waits for EX to leave.
    - es_valid & ms_allow_in → IDLE.
    - flush → IDLE.
  - DRAIN: req = 1 with latched fields; es_mem_ready_go is don't-care because EX is flushed.
    - addr_ok → IDLE and discard_cnt += 1.
    - New issue is blocked while in DRAIN.
- es_mem_ready_go:
  - 1 if ~es_mem_req or suppress due to es_ex/ms_has_int/ws_has_int.
  - 1 in ACC.
  - 1 in IDLE/REQ on the cycle addr_ok handshakes.
  - Otherwise 0.
- ACC exit coincides with ready_go & ms_allow_in. A handshake cycle with ms_allow_in = 1 goes directly to IDLE.
- Encoding:
  - wr = es_mem_we.
  - wstrb: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111; load = 4'b0000.
  - wdata: byte = {4{data[7:0]}}; half = {2{data[15:0]}}; word = data.
  - addr passed unmodified; size = es_mem_size.
- Counters (hs = req & addr_ok):
  - outstanding_next = outstanding + hs − data_ok, excluding DRAIN-state hs.
  - On flush: discard_cnt ← outstanding_next + discard_cnt − (data_ok & discard_cnt ≠ 0), and outstanding ← 0. All in-flight responses now belong to flushed instructions; a data_ok in the flush cycle itself is consumed.
  - Otherwise, data_ok with discard_cnt ≠ 0 decrements discard_cnt, not outstanding.
- ms_data_ok = data_sram_data_ok & (discard_cnt == 0).
- Overflow/underflow of either counter is a design error. Verification asserts it never occurs.

Test Plan:
- Word store, addr 0x1C00_0004, data 0x1234_5678, addr_ok on first cycle → req = 1 for one cycle; wstrb = 1111; wdata = 0x12345678; es_mem_ready_go = 1 in the same cycle; outstanding = 1; next data_ok → ms_data_ok = 1, outstanding = 0.
- Byte store, addr[1:0] = 2, data 0xAB, addr_ok delayed 3 cycles → req held 4 cycles with constant addr/wstrb = 0100/wdata = 0xABABABAB; ready_go = 0 for 3 cycles, then 1.
- Load in REQ, wb_ex pulsed, addr_ok 2 cycles later → state DRAIN; req stays 1 with unchanged fields; discard_cnt = 1 after addr_ok; following data_ok → ms_data_ok = 0, discard_cnt = 0; next load's data_ok passes.
- Two accepted loads (outstanding = 2), ertn_flush → discard_cnt = 2, outstanding = 0; new issue blocked (req = 0) until both data_ok are masked.
- es_ex = 1 or ms_has_int = 1 with a store → req = 0; es_mem_ready_go = 1; counters unchanged.
- reset driven low while in REQ → req = 0 immediately (async); state IDLE; counters 0.

Source files
------------

// File: rtl/stage3_mem_req.sv
// EX-stage data request issuer: drives the SRAM-like data port, gates EX readiness on
// addr_ok, and masks data_ok responses that belong to flushed instructions.
module stage3_mem_req #(
    parameter int MAX_OUTS = 2,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ertn_flush,
    input  logic             wb_ex,
    input  logic             tlb_reflush,
    input  logic             es_valid,
    input  logic             es_mem_req,
    input  logic             es_mem_we,
    input  logic [1:0]       es_mem_size,
    input  logic [31:0]      es_addr,
    input  logic [31:0]      es_store_data,
    input  logic             es_ex,
    input  logic             ms_has_int,
    input  logic             ws_has_int,
    input  logic             ms_allow_in,
    output logic             es_mem_ready_go,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [31:0]      data_sram_addr,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    output logic             ms_data_ok,
    output logic [CNT_W-1:0] mem_outstanding
);
    // state | meaning
    // IDLE  | no request held; port follows EX inputs combinationally
    // REQ   | request latched, waiting for addr_ok
    // ACC   | request accepted, waiting for EX to move on
    // DRAIN | request of a flushed instruction still waiting for addr_ok
    typedef enum logic [1:0] {IDLE, REQ, ACC, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] out_next;
    logic             lat_wr;
    logic [1:0]       lat_size;
    logic [31:0]      lat_addr;
    logic [3:0]       lat_wstrb;
    logic [31:0]      lat_wdata;
    logic [3:0]       enc_wstrb;
    logic [31:0]      enc_wdata;
    logic             flush;
    logic             exc;
    logic             full;
    logic             issue;
    logic             hs;
    logic             hs_live;
    logic             hs_drain;
    logic             dok_live;
    logic             dok_drop;

    assign flush    = ertn_flush | wb_ex | tlb_reflush;
    assign exc      = es_ex | ms_has_int | ws_has_int;
    assign full     = (outstanding + discard_cnt) == CNT_W'(MAX_OUTS);
    assign issue    = es_valid & es_mem_req & ~(exc | flush | full) & (state == IDLE);

    always_comb begin
        enc_wstrb = 4'b0000;
        enc_wdata = es_store_data;
        case (es_mem_size)
            2'd0: begin
                enc_wstrb = 4'b0001 << es_addr[1:0];
                enc_wdata = {4{es_store_data[7:0]}};
            end
            2'd1: begin
                enc_wstrb = es_addr[1] ? 4'b1100 : 4'b0011;
                enc_wdata = {2{es_store_data[15:0]}};
            end
            default: enc_wstrb = 4'b1111;
        endcase
        if (!es_mem_we) enc_wstrb = 4'b0000;
    end

    // Outputs are forced quiet while reset is held, even though IDLE is combinational.
    always_comb begin
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'd0;
        data_sram_wstrb = 4'd0;
        data_sram_wdata = 32'd0;
        if (reset) begin
            if (state == IDLE) begin
                data_sram_req   = issue;
                data_sram_wr    = es_mem_we;
                data_sram_size  = es_mem_size;
                data_sram_addr  = es_addr;
                data_sram_wstrb = enc_wstrb;
                data_sram_wdata = enc_wdata;
            end else begin
                data_sram_req   = (state != ACC);
                data_sram_wr    = lat_wr;
                data_sram_size  = lat_size;
                data_sram_addr  = lat_addr;
                data_sram_wstrb = lat_wstrb;
                data_sram_wdata = lat_wdata;
            end
        end
    end

    assign hs       = data_sram_req & data_sram_addr_ok;
    assign hs_live  = hs & (state != DRAIN);
    assign hs_drain = hs & (state == DRAIN);
    assign dok_drop = data_sram_data_ok & (discard_cnt != '0);
    assign dok_live = data_sram_data_ok & (discard_cnt == '0);
    assign out_next = outstanding + CNT_W'(hs_live) - CNT_W'(dok_live);

    assign ms_data_ok      = reset & dok_live;
    assign mem_outstanding = outstanding;
    assign es_mem_ready_go = ~reset | ~es_mem_req | exc | (state == ACC)
                           | (((state == IDLE) | (state == REQ)) & hs);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            outstanding <= '0;
            discard_cnt <= '0;
            lat_wr      <= 1'b0;
            lat_size    <= 2'd0;
            lat_addr    <= 32'd0;
            lat_wstrb   <= 4'd0;
            lat_wdata   <= 32'd0;
        end else begin
            // On flush every in-flight response becomes stale and moves to the discard count.
            if (flush) begin
                discard_cnt <= out_next + discard_cnt - CNT_W'(dok_drop) + CNT_W'(hs_drain);
                outstanding <= '0;
            end else begin
                discard_cnt <= discard_cnt - CNT_W'(dok_drop) + CNT_W'(hs_drain);
                outstanding <= out_next;
            end
            case (state)
                IDLE: begin
                    if (issue) begin
                        lat_wr    <= es_mem_we;
                        lat_size  <= es_mem_size;
                        lat_addr  <= es_addr;
                        lat_wstrb <= enc_wstrb;
                        lat_wdata <= enc_wdata;
                        if (data_sram_addr_ok) state <= ms_allow_in ? IDLE : ACC;
                        else                   state <= REQ;
                    end
                end
                REQ: begin
                    if (flush)                  state <= data_sram_addr_ok ? IDLE : DRAIN;
                    else if (data_sram_addr_ok) state <= (es_valid & ms_allow_in) ? IDLE : ACC;
                end
                ACC: begin
                    if (flush | (es_valid & ms_allow_in)) state <= IDLE;
                end
                DRAIN: begin
                    if (data_sram_addr_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage3_mem_req.sv
// Scoreboard bench for stage3_mem_req: transaction-level model of requests and in-flight
// responses, directed scenarios followed by randomized traffic.
module tb_stage3_mem_req;
    localparam int MAX_OUTS = 2;

    logic        clk, reset;
    logic        ertn_flush, wb_ex, tlb_reflush;
    logic        es_valid, es_mem_req, es_mem_we;
    logic [1:0]  es_mem_size;
    logic [31:0] es_addr, es_store_data;
    logic        es_ex, ms_has_int, ws_has_int, ms_allow_in;
    logic        es_mem_ready_go;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic        ms_data_ok;
    logic [1:0]  mem_outstanding;

    stage3_mem_req #(.MAX_OUTS(MAX_OUTS), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .ertn_flush(ertn_flush), .wb_ex(wb_ex), .tlb_reflush(tlb_reflush),
        .es_valid(es_valid), .es_mem_req(es_mem_req), .es_mem_we(es_mem_we),
        .es_mem_size(es_mem_size), .es_addr(es_addr), .es_store_data(es_store_data),
        .es_ex(es_ex), .ms_has_int(ms_has_int), .ws_has_int(ws_has_int),
        .ms_allow_in(ms_allow_in), .es_mem_ready_go(es_mem_ready_go),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .ms_data_ok(ms_data_ok), .mem_outstanding(mem_outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    req_t exp_q[$];   // requests predicted to issue, awaiting their handshake
    bit   live_q[$];  // accepted requests awaiting data_ok; 0 = belongs to a flushed instruction
    bit   pend, pend_killed, done, rand_instr;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_wstrb(input logic we, input logic [1:0] size,
                                             input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (!we) return 4'd0;
        case (size)
            2'd0:    return 4'(1 << off);
            2'd1:    return (off >= 2) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'd0:    return (data & 32'hFF) * 32'h0101_0101;
            2'd1:    return (data & 32'hFFFF) * 32'h0001_0001;
            default: return data;
        endcase
    endfunction

    task automatic set_instr(input bit v, input bit mreq, input bit we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] data,
                             input bit ex, input bit msi, input bit wsi);
        es_valid = v; es_mem_req = mreq; es_mem_we = we; es_mem_size = size;
        es_addr = addr; es_store_data = data; es_ex = ex; ms_has_int = msi; ws_has_int = wsi;
    endtask

    task automatic new_instr();
        if (!rand_instr) begin
            set_instr(0, 0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
            return;
        end
        set_instr($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 2)), $urandom, $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 29) == 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        live_q.delete();
        pend = 0; pend_killed = 0; done = 0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic run_cycle(input bit f_ertn, input bit f_wb, input bit f_tlb,
                             input bit a_ok, input bit d_ok, input bit m_allow);
        bit flush, exc, issue, exp_req, hs, rdy, leave;
        int live_cnt;
        ertn_flush = f_ertn; wb_ex = f_wb; tlb_reflush = f_tlb;
        data_sram_addr_ok = a_ok;
        data_sram_data_ok = d_ok && (live_q.size() > 0);
        ms_allow_in = m_allow;
        #1;
        live_cnt = 0;
        foreach (live_q[i]) if (live_q[i]) live_cnt++;
        check("outstanding", 32'(mem_outstanding), 32'(live_cnt));
        flush = f_ertn | f_wb | f_tlb;
        exc   = es_ex | ms_has_int | ws_has_int;
        issue = !pend && es_valid && es_mem_req && !done && !exc && !flush
                && (live_q.size() < MAX_OUTS);
        exp_req = pend || issue;
        check("req_level", 32'(data_sram_req), 32'(exp_req));
        hs = exp_req && a_ok;
        if (issue)
            exp_q.push_back('{es_mem_we, es_mem_size, es_addr,
                              ref_wstrb(es_mem_we, es_mem_size, es_addr),
                              ref_wdata(es_mem_size, es_store_data)});
        rdy = !es_mem_req || exc || done || (hs && !pend_killed);
        if (es_valid && !pend_killed)
            check("ready_go", 32'(es_mem_ready_go), 32'(rdy));
        leave = es_valid && rdy && m_allow;
        @(posedge clk);
        #1;
        if (hs) begin
            live_q.push_back(!flush && !pend_killed);
            if (!pend_killed && !flush && !leave) done = 1;
            pend = 0;
            pend_killed = 0;
        end else if (issue) begin
            pend = 1;
        end
        if (flush) begin
            foreach (live_q[i]) live_q[i] = 0;
            if (pend) pend_killed = 1;
            done = 0;
            new_instr();
        end else if (leave || !es_valid) begin
            done = 0;
            new_instr();
        end
    endtask

    always @(negedge clk) begin : monitor
        req_t e;
        bit   lv;
        if (reset) begin
            if (data_sram_req && data_sram_addr_ok) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", 32'(data_sram_req), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("hs_wr", 32'(data_sram_wr), 32'(e.wr));
                    check("hs_size", 32'(data_sram_size), 32'(e.size));
                    check("hs_addr", data_sram_addr, e.addr);
                    check("hs_wstrb", 32'(data_sram_wstrb), 32'(e.wstrb));
                    check("hs_wdata", data_sram_wdata, e.wdata);
                end
            end
            if (data_sram_data_ok) begin
                if (live_q.size() == 0) begin
                    check("unexpected_data_ok", 32'(data_sram_data_ok), 32'd0);
                end else begin
                    lv = live_q.pop_front();
                    check("ms_data_ok", 32'(ms_data_ok), 32'(lv));
                end
            end
        end
    end

    initial begin
        rand_instr = 0;
        reset = 1'b0;
        ertn_flush = 0; wb_ex = 0; tlb_reflush = 0; ms_allow_in = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 1;
        set_instr(1, 1, 1, 2'd2, 32'h1C00_0000, 32'hDEAD_BEEF, 0, 0, 0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(data_sram_req), 32'd0);
        check("rst_ready_go", 32'(es_mem_ready_go), 32'd1);
        check("rst_outstanding", 32'(mem_outstanding), 32'd0);
        check("rst_ms_data_ok", 32'(ms_data_ok), 32'd0);
        check("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
        data_sram_data_ok = 0;
        set_instr(0, 0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // word store accepted on the first cycle, then its data_ok
        set_instr(1, 1, 1, 2'd2, 32'h1C00_0004, 32'h1234_5678, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 1);
        run_cycle(0, 0, 0, 0, 1, 1);
        run_cycle(0, 0, 0, 0, 0, 1);

        // byte store with addr_ok delayed by three cycles
        set_instr(1, 1, 1, 2'd0, 32'h1C00_0102, 32'h0000_00AB, 0, 0, 0);
        repeat (3) run_cycle(0, 0, 0, 0, 0, 1);
        run_cycle(0, 0, 0, 1, 0, 1);
        run_cycle(0, 0, 0, 0, 1, 1);

        // load flushed while waiting for addr_ok; its response must be masked
        set_instr(1, 1, 0, 2'd2, 32'h1C00_0200, 32'd0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 1);
        run_cycle(0, 1, 0, 0, 0, 1);
        run_cycle(0, 0, 0, 0, 0, 1);
        run_cycle(0, 0, 0, 1, 0, 1);
        set_instr(1, 1, 0, 2'd1, 32'h1C00_0302, 32'd0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 1, 1);
        run_cycle(0, 0, 0, 1, 0, 1);
        run_cycle(0, 0, 0, 0, 1, 1);

        // two accepted loads, then ertn flush; both responses are discarded
        set_instr(1, 1, 0, 2'd2, 32'h1C00_0400, 32'd0, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 1);
        set_instr(1, 1, 0, 2'd2, 32'h1C00_0404, 32'd0, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 1);
        set_instr(1, 1, 0, 2'd2, 32'h1C00_0408, 32'd0, 0, 0, 0);
        run_cycle(1, 0, 0, 1, 0, 1);
        set_instr(1, 1, 1, 2'd1, 32'h1C00_0500, 32'h0000_BEEF, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 1);
        run_cycle(0, 0, 0, 1, 0, 1);
        repeat (4) run_cycle(0, 0, 0, 1, 1, 1);

        // exceptions suppress the request but let EX advance
        set_instr(1, 1, 1, 2'd2, 32'h1C00_0600, 32'h5555_AAAA, 1, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 0);
        set_instr(1, 1, 1, 2'd0, 32'h1C00_0601, 32'h0000_0077, 0, 1, 0);
        run_cycle(0, 0, 0, 1, 0, 0);
        set_instr(0, 0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 1);

        // asynchronous reset while a request waits for addr_ok
        set_instr(1, 1, 1, 2'd2, 32'h1C00_0700, 32'hCAFE_F00D, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", 32'(data_sram_req), 32'd0);
        check("arst_ready_go", 32'(es_mem_ready_go), 32'd1);
        check("arst_outstanding", 32'(mem_outstanding), 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_cycle(0, 0, 0, 1, 0, 1);
        run_cycle(0, 0, 0, 0, 1, 1);

        // randomized traffic
        rand_instr = 1;
        new_instr();
        for (int n = 0; n < 3000; n++) begin
            run_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
                      $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7);
        end

        rand_instr = 0;
        set_instr(0, 0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
        for (int n = 0; n < 40 && (exp_q.size() > 0 || live_q.size() > 0 || pend); n++)
            run_cycle(0, 0, 0, 1, 1, 1);
        check("exp_q_left", 32'(exp_q.size()), 32'd0);
        check("live_q_left", 32'(live_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
